reg_dump_reader: RTL and testbench
==================================

REG_DUMP_READER -- requirements
Module: reg_dump_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of one register word.
REQ-002 SHALL have parameter ADDR_W, default 5, register index width (32 registers).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
REQ-006 SHALL have port first_reg  input  ADDR_W  first register index of the range; sampled only with accepted start.
REQ-007 SHALL have port last_reg  input  ADDR_W  last register index of the range, inclusive; sampled only with accepted start.
REQ-008 SHALL have port rd_addr  output  ADDR_W  read address driven to the register file's combinational read port.
REQ-009 SHALL have port rd_data  input  DATA_W  combinational read data returned for rd_addr in the same cycle.
REQ-010 SHALL have port out_valid  output  1  out_index/out_data hold a word.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the word when high with out_valid.
REQ-012 SHALL have port out_index  output  ADDR_W  register index of the current word.
REQ-013 SHALL have port out_data  output  DATA_W  register contents of the current word.
REQ-014 SHALL have port busy  output  1  high in every state except IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse at dump end.
REQ-016 SHALL have port err  output  1  one-cycle pulse, simultaneous with done, when the range was inverted.

Function
REQ-017 SHALL implement states IDLE, READ, HOLD, FIN.
REQ-018 IDLE: start=1 SHALL capture first_reg into pointer ptr and last_reg into lim.
- If first_reg<=last_reg: next state READ.
- Otherwise: next state FIN with err flagged; no word is emitted.
REQ-019 rd_addr SHALL equal ptr at all times, registered, with no combinational path from inputs.
REQ-020 READ (one cycle): SHALL register rd_data into out_data and ptr into out_index, set out_valid=1, and go to HOLD.
REQ-021 HOLD: out_valid, out_index, out_data SHALL stay stable until out_valid&&out_ready.
REQ-022 HOLD with handshake: if ptr==lim, SHALL clear out_valid and go to FIN; otherwise SHALL set ptr=ptr+1, clear out_valid, and go to READ.
REQ-023 Throughput SHALL be at most one word per 2 cycles, with first out_valid exactly 2 cycles after the accepted start edge.
REQ-024 FIN (one cycle): done=1, plus err=1 if flagged; then SHALL go to IDLE and clear the flag.
REQ-025 start SHALL be ignored in READ, HOLD and FIN; start in the same cycle as FIN->IDLE SHALL also be ignored.
REQ-026 ptr SHALL never wrap: last_reg=31 terminates at index 31 by comparison, without incrementing past it.
REQ-027 first_reg==last_reg SHALL emit exactly one word.
REQ-028 Index 0 SHALL be read and emitted like any other index, with value passed through unmodified.
REQ-029 Changes on first_reg/last_reg after start SHALL have no effect on the running dump.

Reset
REQ-030 rst_n=0 SHALL asynchronously force state IDLE and clear ptr, lim, rd_addr, out_index, out_data, out_valid, busy, done, err and the err flag to 0, in any state.
REQ-031 Reset mid-dump SHALL abandon the dump with no done pulse; the first post-reset start SHALL begin a fresh dump.

Verification
REQ-032 Preload r1=0xd1, r2=0xd2, r6=0xd3; start with range 1..2, out_ready=1 -> words (1,0xd1),(2,0xd2), then done=1 with err=0, busy low the next cycle.
REQ-033 Range 5..6, out_ready held low 5 cycles at first word -> (5,0x0) stable for all 5 cycles, then (6,0xd3), then done.
REQ-034 Range 6..6 -> exactly one word (6,0xd3); range 4..2 -> no out_valid, done=1 and err=1 two cycles after start.
REQ-035 Range 30..31 with r31=0xffffffff -> last word (31,0xffffffff), then done; rd_addr never shows 0 after 31 before FIN.
REQ-036 Start pulsed again while busy during range 1..2 -> ignored, same two words; rst_n low during HOLD -> all outputs 0 immediately, no done pulse.

Source files
------------

// File: rtl/reg_dump_reader.sv
// Walks an inclusive range of register indices through a combinational read
// port and streams (index, data) words out over a valid/ready handshake.
module reg_dump_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_reg,
  input  logic [ADDR_W-1:0] last_reg,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_index,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [1:0] FIN  = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] lim;
  logic              err_flag;

  // The read address is the pointer register itself, so it never depends on inputs.
  assign rd_addr = ptr;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      lim       <= '0;
      err_flag  <= 1'b0;
      out_valid <= 1'b0;
      out_index <= '0;
      out_data  <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            ptr <= first_reg;
            lim <= last_reg;
            if (first_reg <= last_reg) begin
              state <= READ;
            end else begin
              err_flag <= 1'b1;
              state    <= FIN;
            end
          end
        end
        READ: begin
          out_data  <= rd_data;
          out_index <= ptr;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          // Compare before incrementing so a range ending at the top index never wraps.
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            if (ptr == lim) begin
              state <= FIN;
            end else begin
              ptr   <= ptr + 1'b1;
              state <= READ;
            end
          end
        end
        FIN: begin
          done     <= 1'b1;
          err      <= err_flag;
          err_flag <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Scoreboard bench for reg_dump_reader: a range-level model queues expected words
// and end events; a negedge monitor pops and compares them as the DUT emits.
module tb_reg_dump_reader;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic [AW-1:0] first_reg = '0;
  logic [AW-1:0] last_reg = '0;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] out_index;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] out_data;
  logic          out_valid, busy, done, err;

  logic [DW-1:0] regs [32];
  assign rd_data = regs[rd_addr];

  always #5 clk = ~clk;

  reg_dump_reader #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .first_reg(first_reg), .last_reg(last_reg),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_data(out_data), .busy(busy), .done(done), .err(err)
  );

  typedef struct {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
  } word_t;

  int    total = 0;
  int    bad = 0;
  word_t exp_words[$];
  bit    exp_ends[$];
  int    ready_mode = 0;   // 0: always ready, 1: random, 2: held low
  int    done_cnt = 0;
  bit    cur_inverted = 1'b0;
  int    cur_lo = 0;
  int    cur_hi = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (ready_mode == 0) out_ready = 1'b1;
    else if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
    else out_ready = 1'b0;
  end

  // Monitor: handshakes, stall stability, address range, end events.
  logic          stall_pend = 1'b0;
  logic [AW-1:0] st_idx;
  logic [DW-1:0] st_data;
  bit            prev_done = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_pend = 1'b0;
      prev_done  = 1'b0;
    end else begin
      if (stall_pend) begin
        check("stall_valid", out_valid, 1);
        check("stall_index", out_index, st_idx);
        check("stall_data", out_data, st_data);
      end
      stall_pend = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          if (exp_words.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_word: got idx %0d data %0h want none", out_index, out_data);
          end else begin
            word_t w;
            w = exp_words.pop_front();
            check("word_index", out_index, w.idx);
            check("word_data", out_data, w.data);
            $display("word idx=%0d data=%08h", out_index, out_data);
          end
        end else begin
          stall_pend = 1'b1;
          st_idx     = out_index;
          st_data    = out_data;
        end
      end
      if (busy && !cur_inverted) begin
        total++;
        if (int'(rd_addr) < cur_lo || int'(rd_addr) > cur_hi) begin
          bad++;
          $display("FAIL rd_addr_range: got %0d want %0d..%0d", rd_addr, cur_lo, cur_hi);
        end
      end
      if (prev_done) check("busy_after_done", busy, 0);
      if (done) begin
        if (exp_ends.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done: got done err=%0b want none", err);
        end else begin
          bit e;
          e = exp_ends.pop_front();
          check("done_err", err, e);
          $display("done err=%0b", err);
        end
        done_cnt++;
      end else begin
        check("err_alone", err, 0);
      end
      prev_done = done;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_index"}, out_index, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  // One dump: model the expected stream, start it, check latency, wait for done.
  task automatic do_dump(input int f, input int l, input int mode, input bit pulse, input bit stall);
    int lat;
    int n;
    int d0;
    cur_lo = f;
    cur_hi = l;
    cur_inverted = (f > l);
    if (f <= l) begin
      for (int i = f; i <= l; i++) begin
        word_t w;
        w.idx  = AW'(i);
        w.data = regs[i];
        exp_words.push_back(w);
      end
    end
    exp_ends.push_back(f > l);
    d0 = done_cnt;
    @(posedge clk); #1;
    check("idle_before_start", busy, 0);
    start = 1'b1;
    first_reg = AW'(f);
    last_reg = AW'(l);
    ready_mode = stall ? 2 : mode;
    @(posedge clk); #1;
    start = 1'b0;
    first_reg = AW'($urandom);
    last_reg = AW'($urandom);
    lat = 0;
    while (!(out_valid || done) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("first_latency", lat, 2);
    if (stall) begin
      repeat (4) @(negedge clk);
      ready_mode = 0;
    end
    n = 0;
    while (done_cnt == d0 && n < 500) begin
      @(posedge clk); #1;
      n++;
      if (pulse && busy) begin
        start = 1'($urandom_range(0, 1));
        first_reg = AW'($urandom);
        last_reg = AW'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (n >= 500) begin
      total++; bad++;
      $display("FAIL done_timeout: got no done want done for %0d..%0d", f, l);
    end
    @(negedge clk);
  endtask

  initial begin
    int lat;
    for (int i = 0; i < 32; i++) regs[i] = '0;
    regs[1] = 32'hd1;
    regs[2] = 32'hd2;
    regs[6] = 32'hd3;
    regs[31] = 32'hffffffff;

    #2 rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(posedge clk);
    @(negedge clk); #2 rst_n = 1'b1;

    do_dump(1, 2, 0, 0, 0);
    do_dump(5, 6, 0, 0, 1);
    do_dump(6, 6, 0, 0, 0);
    do_dump(4, 2, 0, 0, 0);
    do_dump(30, 31, 0, 0, 0);
    do_dump(1, 2, 0, 1, 0);

    // Reset while a word is held: everything clears at once and no done follows.
    @(posedge clk); #1;
    ready_mode = 2;
    start = 1'b1; first_reg = 5'd1; last_reg = 5'd2;
    cur_lo = 1; cur_hi = 2; cur_inverted = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("hold_reached", out_valid, 1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1 check_all_zero("mid_reset");
    exp_words.delete();
    exp_ends.delete();
    repeat (3) begin
      @(negedge clk);
      check("reset_no_done", done, 0);
    end
    #2 rst_n = 1'b1;
    ready_mode = 0;
    repeat (3) begin
      @(negedge clk);
      check("post_reset_done", done, 0);
      check("post_reset_busy", busy, 0);
    end
    do_dump(1, 2, 0, 0, 0);

    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    do_dump(0, 3, 1, 0, 0);
    for (int t = 0; t < 40; t++) begin
      int f;
      int l;
      f = $urandom_range(0, 31);
      l = ($urandom_range(0, 3) == 0) ? 31 : $urandom_range(0, 31);
      do_dump(f, l, $urandom_range(0, 1), 1'($urandom_range(0, 1)), 0);
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
    end

    repeat (3) @(negedge clk);
    check("words_left", exp_words.size(), 0);
    check("ends_left", exp_ends.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
